// File: rtl/program_counter.sv
// rtl/program_counter.sv - fetch/decode/execute sequencer holding PC and IR
module program_counter #(
    parameter int                 WIDTH    = 8,
    parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             espera,
    input  logic [WIDTH-1:0] instrucao,
    input  logic             salto,
    input  logic [WIDTH-1:0] alvo,
    input  logic             halt_req,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] ir,
    output logic [1:0]       fase,
    output logic             exec_en,
    output logic             parado
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'b00,
        S_DECODE  = 2'b01,
        S_EXECUTE = 2'b10,
        S_HALTED  = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_ir;

    // Phase register; reset wins over stall and over HALTED.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next phase: stall holds the current phase, HALTED is absorbing.
    always_comb begin
        w_next_state = r_state;
        if (!espera) begin
            case (r_state)
                S_FETCH:   w_next_state = S_DECODE;
                S_DECODE:  w_next_state = S_EXECUTE;
                S_EXECUTE: w_next_state = halt_req ? S_HALTED : S_FETCH;
                default:   w_next_state = S_HALTED;
            endcase
        end
    end

    // PC and IR: IR loads only leaving FETCH, PC updates only leaving EXECUTE without a halt.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc <= RESET_PC;
            r_ir <= '0;
        end else if (!espera) begin
            case (r_state)
                S_FETCH: begin
                    r_ir <= instrucao;
                end
                S_EXECUTE: begin
                    if (!halt_req) begin
                        r_pc <= salto ? alvo : r_pc + WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from registered state; exec_en is the only term gated by the stall input.
    always_comb begin
        pc      = r_pc;
        ir      = r_ir;
        fase    = r_state;
        exec_en = (r_state == S_EXECUTE) && !espera;
        parado  = (r_state == S_HALTED);
    end

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - vector table and scoreboard bench for program_counter
module tb_program_counter;

    typedef struct {
        logic       rst;
        logic       esp;
        logic       sal;
        logic [7:0] alv;
        logic       hlt;
        logic [7:0] e_pc;
        logic [7:0] e_ir;
        logic [1:0] e_fase;
        logic       e_ex;
        logic       e_par;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset0, espera0, salto0, halt0;
    logic [7:0] alvo0, instr0, pc0, ir0;
    logic [1:0] fase0;
    logic       ex0, par0;

    logic       reset1, espera1, salto1, halt1;
    logic [7:0] alvo1, instr1, pc1, ir1;
    logic [1:0] fase1;
    logic       ex1, par1;

    int passed = 0;
    int total  = 0;

    vec_t tbl[$];
    vec_t sb[$];

    always #5 clock = ~clock;

    assign instr0 = 8'hA0 + pc0;
    assign instr1 = 8'hC0 + pc1;

    program_counter #(.WIDTH(8), .RESET_PC(8'h00)) dut0 (
        .clock(clock), .reset(reset0), .espera(espera0), .instrucao(instr0),
        .salto(salto0), .alvo(alvo0), .halt_req(halt0),
        .pc(pc0), .ir(ir0), .fase(fase0), .exec_en(ex0), .parado(par0)
    );

    program_counter #(.WIDTH(8), .RESET_PC(8'hFF)) dut1 (
        .clock(clock), .reset(reset1), .espera(espera1), .instrucao(instr1),
        .salto(salto1), .alvo(alvo1), .halt_req(halt1),
        .pc(pc1), .ir(ir1), .fase(fase1), .exec_en(ex1), .parado(par1)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %02h expected %02h", name, act, exp);
    endtask

    task automatic add(input logic rst, input logic esp, input logic sal, input logic [7:0] alv,
                       input logic hlt, input logic [7:0] p, input logic [7:0] i,
                       input logic [1:0] f, input logic ex, input logic par);
        vec_t v;
        v.rst = rst; v.esp = esp; v.sal = sal; v.alv = alv; v.hlt = hlt;
        v.e_pc = p; v.e_ir = i; v.e_fase = f; v.e_ex = ex; v.e_par = par;
        tbl.push_back(v);
    endtask

    task automatic step1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        vec_t v;
        vec_t e;
        string tag;

        // reset held two cycles with stall and jump asserted
        add(1, 1, 1, 8'h77, 0, 8'h00, 8'h00, 2'd0, 0, 0);
        add(1, 1, 1, 8'h77, 0, 8'h00, 8'h00, 2'd0, 0, 0);
        // sequential instructions 0 and 1
        add(0, 0, 0, 8'h00, 0, 8'h00, 8'hA0, 2'd1, 0, 0);
        add(0, 0, 0, 8'h00, 0, 8'h00, 8'hA0, 2'd2, 1, 0);
        add(0, 0, 0, 8'h00, 0, 8'h01, 8'hA0, 2'd0, 0, 0);
        add(0, 0, 0, 8'h00, 0, 8'h01, 8'hA1, 2'd1, 0, 0);
        add(0, 0, 0, 8'h00, 0, 8'h01, 8'hA1, 2'd2, 1, 0);
        add(0, 0, 0, 8'h00, 0, 8'h02, 8'hA1, 2'd0, 0, 0);
        // instruction 2 with a 4-cycle stall in DECODE (7 cycles total)
        add(0, 0, 0, 8'h00, 0, 8'h02, 8'hA2, 2'd1, 0, 0);
        for (int k = 0; k < 4; k++)
            add(0, 1, 1, 8'h99, 1, 8'h02, 8'hA2, 2'd1, 0, 0);
        add(0, 0, 0, 8'h00, 0, 8'h02, 8'hA2, 2'd2, 1, 0);
        add(0, 0, 0, 8'h00, 0, 8'h03, 8'hA2, 2'd0, 0, 0);
        // instruction 3 with a stall in EXECUTE that must ignore salto/halt
        add(0, 0, 0, 8'h00, 0, 8'h03, 8'hA3, 2'd1, 0, 0);
        add(0, 0, 0, 8'h00, 0, 8'h03, 8'hA3, 2'd2, 1, 0);
        add(0, 1, 1, 8'h77, 1, 8'h03, 8'hA3, 2'd2, 0, 0);
        add(0, 0, 0, 8'h00, 0, 8'h04, 8'hA3, 2'd0, 0, 0);
        // salto pulse during FETCH/DECODE only
        add(0, 0, 1, 8'h3C, 0, 8'h04, 8'hA4, 2'd1, 0, 0);
        add(0, 0, 1, 8'h3C, 0, 8'h04, 8'hA4, 2'd2, 1, 0);
        add(0, 0, 0, 8'h3C, 0, 8'h05, 8'hA4, 2'd0, 0, 0);
        // jump taken to 0x10
        add(0, 0, 0, 8'h00, 0, 8'h05, 8'hA5, 2'd1, 0, 0);
        add(0, 0, 0, 8'h00, 0, 8'h05, 8'hA5, 2'd2, 1, 0);
        add(0, 0, 1, 8'h10, 0, 8'h10, 8'hA5, 2'd0, 0, 0);
        // halt beats salto at pc 0x10
        add(0, 0, 0, 8'h00, 0, 8'h10, 8'hB0, 2'd1, 0, 0);
        add(0, 0, 0, 8'h00, 0, 8'h10, 8'hB0, 2'd2, 1, 0);
        add(0, 0, 1, 8'h55, 1, 8'h10, 8'hB0, 2'd3, 0, 1);
        for (int k = 0; k < 10; k++)
            add(0, k[0], 1, 8'(8'h55 + k), k[1], 8'h10, 8'hB0, 2'd3, 0, 1);
        // reset out of HALTED, then reset mid-EXECUTE with salto high
        add(1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 2'd0, 0, 0);
        add(0, 0, 0, 8'h00, 0, 8'h00, 8'hA0, 2'd1, 0, 0);
        add(0, 0, 0, 8'h00, 0, 8'h00, 8'hA0, 2'd2, 1, 0);
        add(1, 0, 1, 8'h99, 0, 8'h00, 8'h00, 2'd0, 0, 0);
        add(0, 0, 0, 8'h00, 0, 8'h00, 8'hA0, 2'd1, 0, 0);
        add(0, 0, 0, 8'h00, 0, 8'h00, 8'hA0, 2'd2, 1, 0);
        add(0, 0, 0, 8'h00, 0, 8'h01, 8'hA0, 2'd0, 0, 0);

        reset0 = 1; espera0 = 0; salto0 = 0; alvo0 = 0; halt0 = 0;
        reset1 = 1; espera1 = 0; salto1 = 0; alvo1 = 0; halt1 = 0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            v = tbl[i];
            reset0 = v.rst; espera0 = v.esp; salto0 = v.sal; alvo0 = v.alv; halt0 = v.hlt;
            sb.push_back(v);
            step1();
            if (sb.size() == 0) begin
                total++;
                $display("FAIL scoreboard_empty at vector %0d", i);
            end else begin
                e = sb.pop_front();
                tag = $sformatf("v%0d", i);
                check({tag, "_pc"},      pc0,          e.e_pc);
                check({tag, "_ir"},      ir0,          e.e_ir);
                check({tag, "_fase"},    {6'd0, fase0}, {6'd0, e.e_fase});
                check({tag, "_exec_en"}, {7'd0, ex0},  {7'd0, e.e_ex});
                check({tag, "_parado"},  {7'd0, par0}, {7'd0, e.e_par});
            end
        end
        total++;
        if (sb.size() == 0) passed++;
        else $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size());

        // RESET_PC = FF: wrap on increment, then a taken jump to 3C
        @(negedge clock);
        reset1 = 1;
        step1();
        check("w_reset_pc", pc1, 8'hFF);
        check("w_reset_fase", {6'd0, fase1}, 8'd0);
        @(negedge clock);
        reset1 = 0;
        step1();
        check("w_fetch_ir", ir1, 8'hBF);
        @(negedge clock);
        step1();
        check("w_decode_fase", {6'd0, fase1}, 8'd2);
        @(negedge clock);
        step1();
        check("w_wrap_pc", pc1, 8'h00);
        @(negedge clock);
        step1();
        check("w_fetch2_ir", ir1, 8'hC0);
        @(negedge clock);
        step1();
        check("w_exec_en", {7'd0, ex1}, 8'd1);
        @(negedge clock);
        salto1 = 1; alvo1 = 8'h3C;
        step1();
        check("w_jump_pc", pc1, 8'h3C);
        check("w_jump_fase", {6'd0, fase1}, 8'd0);
        @(negedge clock);
        salto1 = 0;
        step1();
        check("w_jump_ir", ir1, 8'hFC);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
